membus_arb: RTL and testbench

- Two-requester arbiter in front of the memory/GPIO bus: port 0 is the CPU, port 1 is a DMA/loader engine.
- Picks one requester per cycle, round-robin, with an optional bus lock for atomic multi-cycle sequences.
- Drives the bus address, write data and write strobe from the winner.
- Routes the one-cycle-latency bus read data back to the requester that issued the access.

---
 rtl/membus_pkg.sv | 22 ++
 rtl/rr_pick2.sv | 25 ++
 rtl/membus_arb.sv | 120 ++++++++++++
 tb/tb_membus_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// Shared types and address map for the memory/GPIO bus and its arbiter.
package membus_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic [8:0] RAM_BASE  = 9'h000;
    localparam logic [8:0] GPIO_BASE = 9'h100;

    // Bit n set means port n may be granted in this state.
    function automatic logic [1:0] state_mask(input arb_state_t s);
        case (s)
            LOCK0:   return 2'b01;
            LOCK1:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot grant from masked requests, favouring
// the port that did not win last.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic r0;
    logic r1;

    always_comb begin
        r0  = req0 & mask[0];
        r1  = req1 & mask[1];
        gnt = 2'b00;
        if (r0 && r1) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = {r1, r0};
        end
    end

endmodule

// File: rtl/membus_arb.sv
// CPU/DMA arbiter for the memory/GPIO bus: round-robin with optional bus lock,
// bus drive from the winner, and routing of one-cycle-latency read data.
module membus_arb
    import membus_pkg::*;
#(
    parameter int width      = 16,
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [width-1:0]      wdata0,
    input  logic [width-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [width-1:0]      rdata0,
    output logic [width-1:0]      rdata1,
    output logic [addr_width-1:0] bus_addr,
    output logic [width-1:0]      bus_wdata,
    output logic                  bus_we,
    input  logic [width-1:0]      bus_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last;
    logic       tag_valid;
    logic       tag_owner;
    logic [1:0] mask;
    logic [1:0] pick;

    // Masking everything during reset keeps the bus quiet in that cycle.
    always_comb begin
        mask = reset ? 2'b00 : state_mask(state);
    end

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .mask (mask),
        .gnt  (pick)
    );

    assign gnt0 = pick[0];
    assign gnt1 = pick[1];

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        if (gnt0) begin
            bus_addr  = addr0;
            bus_wdata = wdata0;
            bus_we    = we0;
        end else if (gnt1) begin
            bus_addr  = addr1;
            bus_wdata = wdata1;
            bus_we    = we1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB: begin
                if (gnt0 && lock0) begin
                    state_next = LOCK0;
                end else if (gnt1 && lock1) begin
                    state_next = LOCK1;
                end
            end
            LOCK0: begin
                if (gnt0 && !lock0) begin
                    state_next = ARB;
                end
            end
            LOCK1: begin
                if (gnt1 && !lock1) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            last      <= 1'b1;
            tag_valid <= 1'b0;
            tag_owner <= 1'b0;
        end else begin
            state     <= state_next;
            if (gnt0 || gnt1) begin
                last <= gnt1;
            end
            tag_valid <= (gnt0 && !we0) || (gnt1 && !we1);
            tag_owner <= gnt1;
        end
    end

    // A tag left over from the cycle before reset must not surface as rvalid.
    always_comb begin
        rvalid0 = tag_valid && !tag_owner && !reset;
        rvalid1 = tag_valid && tag_owner && !reset;
        rdata0  = rvalid0 ? bus_rdata : '0;
        rdata1  = rvalid1 ? bus_rdata : '0;
    end

endmodule

// File: tb/tb_membus_arb.sv
// Self-checking bench for membus_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_membus_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [8:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;

    logic [15:0] mem    [0:511];
    logic [15:0] refMem [0:511];

    int          owner;
    int          lastWin;
    bit          pendValid;
    int          pendPort;
    logic [15:0] pendData;
    int          expWinner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    membus_arb #(.width(16), .addr_width(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_rdata (bus_rdata)
    );

    // Bus-side memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus_we) mem[bus_addr] <= bus_wdata;
        bus_rdata <= mem[bus_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle, checks every output against the model, advances the model.
    task automatic applyStimulus(input bit rst,
                                 input bit r0, input bit w0, input bit l0,
                                 input logic [8:0] a0, input logic [15:0] d0,
                                 input bit r1, input bit w1, input bit l1,
                                 input logic [8:0] a1, input logic [15:0] d1);
        int          win;
        bit          rv0, rv1, wWe, wLock;
        logic [8:0]  wAddr;
        logic [15:0] wData;
        reset = rst;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        win = -1;
        if (!rst) begin
            if (owner >= 0) begin
                if ((owner == 0 && r0) || (owner == 1 && r1)) win = owner;
            end else if (r0 && r1) begin
                win = 1 - lastWin;
            end else if (r0) begin
                win = 0;
            end else if (r1) begin
                win = 1;
            end
        end
        expWinner = win;
        wAddr = (win == 0) ? a0 : (win == 1) ? a1 : 9'h000;
        wData = (win == 0) ? d0 : (win == 1) ? d1 : 16'h0000;
        wWe   = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
        wLock = (win == 0) ? l0 : (win == 1) ? l1 : 1'b0;
        rv0 = !rst && pendValid && pendPort == 0;
        rv1 = !rst && pendValid && pendPort == 1;
        checkOutput("gnt0", gnt0, win == 0);
        checkOutput("gnt1", gnt1, win == 1);
        checkOutput("oneHot", gnt0 & gnt1, 0);
        checkOutput("bus_addr", bus_addr, wAddr);
        checkOutput("bus_wdata", bus_wdata, wData);
        checkOutput("bus_we", bus_we, wWe);
        checkOutput("rvalid0", rvalid0, rv0);
        checkOutput("rvalid1", rvalid1, rv1);
        checkOutput("rdata0", rdata0, rv0 ? pendData : 16'h0000);
        checkOutput("rdata1", rdata1, rv1 ? pendData : 16'h0000);
        if (rst) begin
            owner = -1;
            lastWin = 1;
            pendValid = 0;
        end else begin
            pendValid = (win >= 0) && !wWe;
            pendPort = win;
            if (win >= 0) begin
                pendData = refMem[wAddr];
                lastWin = win;
                if (wWe) refMem[wAddr] = wData;
                if (owner < 0) owner = wLock ? win : -1;
                else owner = wLock ? owner : -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    bit          pr [2];
    bit          pw [2];
    bit          pl [2];
    logic [8:0]  pa [2];
    logic [15:0] pd [2];

    initial begin
        logic [15:0] v;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        owner = -1; lastWin = 1; pendValid = 0; pendPort = 0; pendData = '0; expWinner = -1;
        for (int i = 0; i < 512; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            refMem[i] = v;
        end
        mem[16] = 16'hBEEF;
        refMem[16] = 16'hBEEF;

        // Reset with requests pending: nothing may be granted.
        applyStimulus(1, 1,0,0,9'h001,0, 1,0,0,9'h002,0);
        applyStimulus(1, 1,0,0,9'h001,0, 1,0,0,9'h002,0);

        // Lone CPU read of 0x010.
        applyStimulus(0, 1,0,0,9'h010,0, 0,0,0,9'h000,0);
        checkOutput("tp1Rvalid0", rvalid0, 1);
        checkOutput("tp1Rdata0", rdata0, 16'hBEEF);
        applyStimulus(0, 0,0,0,9'h000,0, 0,0,0,9'h000,0);

        // Continuous contention straight after reset alternates 0,1,0,1.
        applyStimulus(1, 0,0,0,9'h000,0, 0,0,0,9'h000,0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1,0,0,9'h001,0, 1,0,0,9'h002,0);
            checkOutput("tp2Winner", expWinner, i % 2);
        end
        applyStimulus(0, 0,0,0,9'h000,0, 0,0,0,9'h000,0);

        // Locked write then unlocked read by port 1 while port 0 waits.
        applyStimulus(1, 0,0,0,9'h000,0, 0,0,0,9'h000,0);
        applyStimulus(0, 1,0,0,9'h005,0, 1,1,1,9'h100,16'h00FF);
        applyStimulus(0, 1,0,0,9'h005,0, 1,1,1,9'h100,16'h00FF);
        applyStimulus(0, 1,0,0,9'h005,0, 1,0,0,9'h100,0);
        checkOutput("tp3Rdata1", rdata1, 16'h00FF);
        checkOutput("tp3Gnt0After", gnt0, 1);
        applyStimulus(0, 1,0,0,9'h005,0, 0,0,0,9'h000,0);

        // Lock held while the owner goes idle for three cycles.
        applyStimulus(0, 0,0,0,9'h000,0, 1,1,1,9'h101,16'h0003);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1,0,0,9'h007,0, 0,0,0,9'h000,0);
        applyStimulus(0, 1,0,0,9'h007,0, 1,0,0,9'h101,0);
        applyStimulus(0, 1,0,0,9'h007,0, 0,0,0,9'h000,0);

        // Read granted just before reset is dropped; first contention goes to port 0.
        applyStimulus(0, 1,0,0,9'h020,0, 0,0,0,9'h000,0);
        applyStimulus(1, 1,0,0,9'h020,0, 1,0,0,9'h021,0);
        applyStimulus(0, 1,0,0,9'h020,0, 1,0,0,9'h021,0);
        checkOutput("tp5FirstWinner", rvalid0, 1);
        applyStimulus(0, 0,0,0,9'h000,0, 1,0,0,9'h021,0);

        // Write by port 0, then read of the same word by port 1.
        applyStimulus(0, 1,1,0,9'h030,16'h1234, 0,0,0,9'h000,0);
        checkOutput("tp6NoRvalid0", rvalid0, 0);
        applyStimulus(0, 0,0,0,9'h000,0, 1,0,0,9'h030,0);
        checkOutput("tp6Rdata1", rdata1, 16'h1234);
        checkOutput("tp6Rvalid0", rvalid0, 0);
        applyStimulus(0, 0,0,0,9'h000,0, 0,0,0,9'h000,0);

        // Random traffic: each port holds its request until the model grants it.
        for (int p = 0; p < 2; p++) pr[p] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p] && $urandom_range(0, 99) < 60) begin
                    pr[p] = 1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pl[p] = ($urandom_range(0, 3) == 0);
                    pa[p] = ($urandom_range(0, 3) == 0) ? (9'h100 | 9'($urandom_range(0, 1)))
                                                        : 9'($urandom_range(0, 15));
                    pd[p] = 16'($urandom);
                end
            end
            applyStimulus($urandom_range(0, 59) == 0,
                          pr[0], pw[0], pl[0], pa[0], pd[0],
                          pr[1], pw[1], pl[1], pa[1], pd[1]);
            if (expWinner >= 0) pr[expWinner] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
